// File: rtl/apb_arb2_if.sv
// APB bus bundle shared by the two upstream masters and the downstream slave
// port of apb_arb2. "master" is the side that initiates transfers, "slave"
// is the side that answers them.
interface apb_arb2_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_arb2.sv
// Two-master / one-slave APB arbiter. Round-robin between the UART bridge
// (m0) and the local sequencer (m1), regenerates a clean SETUP/ACCESS
// sequence toward the slave, and aborts a transfer whose slave never answers
// so the debug path cannot be locked up. Every output is a flop.
module apb_arb2 #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 32,
    parameter int                TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] TO_DATA = 32'hDEAD_BEEF
) (
    input  logic       clk,
    input  logic       rst_n,
    apb_arb2_if.slave  m0,
    apb_arb2_if.slave  m1,
    apb_arb2_if.master s,
    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state;
    logic              last_grant;   // index of the most recently granted master
    logic [CNT_W-1:0]  cnt;
    logic              win1;
    logic              timed_out;
    logic              xfer_end;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // The upstream access phase is implied by holding psel; the arbiter
    // generates its own penable toward the slave, so master penable is unused.
    logic unused_penables;
    assign unused_penables = m0.penable ^ m1.penable;

    // Arbitration choice and end-of-access response selection.
    always_comb begin
        win1      = m1.psel && (!m0.psel || !last_grant);
        timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST) && !s.pready;
        xfer_end  = s.pready || timed_out;
        rsp_data  = s.pready ? s.prdata : TO_DATA;
        rsp_err   = s.pready ? s.pslverr : 1'b1;
    end

    // Arbiter FSM; all bus outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            s.psel      <= 1'b0;
            s.penable   <= 1'b0;
            s.pwrite    <= 1'b0;
            s.paddr     <= '0;
            s.pwdata    <= '0;
            m0.pready   <= 1'b0;
            m0.prdata   <= '0;
            m0.pslverr  <= 1'b0;
            m1.pready   <= 1'b0;
            m1.prdata   <= '0;
            m1.pslverr  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0.psel || m1.psel) begin
                        s.psel     <= 1'b1;
                        s.pwrite   <= win1 ? m1.pwrite : m0.pwrite;
                        s.paddr    <= win1 ? m1.paddr  : m0.paddr;
                        s.pwdata   <= win1 ? m1.pwdata : m0.pwdata;
                        grant      <= win1 ? 2'b10 : 2'b01;
                        last_grant <= win1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    s.penable <= 1'b1;
                    cnt       <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (xfer_end) begin
                        s.psel      <= 1'b0;
                        s.penable   <= 1'b0;
                        grant       <= 2'b00;
                        timeout_err <= timed_out;
                        if (last_grant) begin
                            m1.pready  <= 1'b1;
                            m1.prdata  <= rsp_data;
                            m1.pslverr <= rsp_err;
                        end else begin
                            m0.pready  <= 1'b1;
                            m0.prdata  <= rsp_data;
                            m0.pslverr <= rsp_err;
                        end
                        state <= DONE;
                    end
                end
                default: begin
                    // DONE: single-cycle response, then back to arbitration.
                    m0.pready  <= 1'b0;
                    m0.prdata  <= '0;
                    m0.pslverr <= 1'b0;
                    m1.pready  <= 1'b0;
                    m1.prdata  <= '0;
                    m1.pslverr <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arb2.sv
// Bench for apb_arb2: two master drivers, an address-decoded slave model,
// and a scoreboard monitor that checks responses and arbitration order.
module tb_apb_arb2;

    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
    localparam int          TMO     = 16;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    apb_arb2_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
    apb_arb2_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();
    apb_arb2_if #(.ADDR_W(16), .DATA_W(32)) s_if ();

    apb_arb2 #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TMO), .TO_DATA(TO_DATA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [15:0] cur_addr[2];
    logic        cur_wr[2];
    logic [31:0] cur_wdata[2];
    int          last_served = 1;
    logic [1:0]  req_snap = 2'b00;

    // Slave model rules: waits = addr[1:0], never ready if addr[15:12]==F,
    // error if addr[11:8]==E, read data derived from the address.
    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        return {a ^ 16'h0206, a};
    endfunction

    function automatic bit hangs(input logic [15:0] a);
        return a[15:12] == 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic drive(input int n, input logic sel, input logic en, input logic wr,
                         input logic [15:0] a, input logic [31:0] d);
        if (n == 0) begin
            m0_if.psel = sel; m0_if.penable = en; m0_if.pwrite = wr;
            m0_if.paddr = a; m0_if.pwdata = d;
        end else begin
            m1_if.psel = sel; m1_if.penable = en; m1_if.pwrite = wr;
            m1_if.paddr = a; m1_if.pwdata = d;
        end
    endtask

    function automatic logic get_pready(input int n);
        return (n == 0) ? m0_if.pready : m1_if.pready;
    endfunction

    // One APB transfer from master n; exp_cyc < 0 skips the latency check.
    task automatic do_xfer(input int n, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input int exp_cyc);
        exp_t e;
        int   cyc;
        bit   seen;
        e.to   = hangs(a);
        e.data = e.to ? TO_DATA : rd_fn(a);
        e.err  = e.to || (a[11:8] == 4'hE);
        if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        cur_addr[n]  = a;
        cur_wr[n]    = wr;
        cur_wdata[n] = d;
        drive(n, 1'b1, 1'b0, wr, a, d);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) drive(n, 1'b1, 1'b1, wr, a, d);
            if (get_pready(n)) seen = 1;
        end
        if (!seen) fail($sformatf("m%0d_no_pready", n));
        else if (exp_cyc >= 0) check($sformatf("m%0d_latency", n), cyc, exp_cyc);
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic rand_master(input int n, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            do_xfer(n, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, -1);
        end
    endtask

    // Request snapshot as seen by the arbiter at each rising edge.
    always @(posedge clk) req_snap <= {m1_if.psel, m0_if.psel};

    // Slave model: answers after addr[1:0] wait states unless it hangs.
    initial begin
        int  sl_cnt;
        bit  acc_prev;
        sl_cnt = 0;
        acc_prev = 0;
        s_if.pready = 1'b0; s_if.prdata = '0; s_if.pslverr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && s_if.psel && s_if.penable) begin
                sl_cnt         = acc_prev ? sl_cnt + 1 : 0;
                s_if.pready    = !hangs(s_if.paddr) && (sl_cnt == int'(s_if.paddr[1:0]));
                s_if.prdata    = rd_fn(s_if.paddr);
                s_if.pslverr   = (s_if.paddr[11:8] == 4'hE);
                acc_prev       = 1;
            end else begin
                s_if.pready = 1'b0; s_if.prdata = '0; s_if.pslverr = 1'b0;
                acc_prev = 0;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    int   owner;
    int   acc_cnt = 0;
    int   acc_exp = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_if.pready || m1_if.pready) begin
                check("single_pready", 32'(m0_if.pready & m1_if.pready), 32'd0);
                if (m0_if.pready) begin
                    if (exp_q0.size() == 0) fail("m0_unexpected_pready");
                    else begin
                        mon_e = exp_q0.pop_front();
                        check("m0_prdata", m0_if.prdata, mon_e.data);
                        check("m0_pslverr", 32'(m0_if.pslverr), 32'(mon_e.err));
                        check("m0_timeout_err", 32'(timeout_err), 32'(mon_e.to));
                        check("m1_prdata_idle", m1_if.prdata, 32'd0);
                    end
                end else begin
                    if (exp_q1.size() == 0) fail("m1_unexpected_pready");
                    else begin
                        mon_e = exp_q1.pop_front();
                        check("m1_prdata", m1_if.prdata, mon_e.data);
                        check("m1_pslverr", 32'(m1_if.pslverr), 32'(mon_e.err));
                        check("m1_timeout_err", 32'(timeout_err), 32'(mon_e.to));
                        check("m0_prdata_idle", m0_if.prdata, 32'd0);
                    end
                end
                check("done_grant", 32'(grant), 32'd0);
                check("done_s_psel", 32'(s_if.psel), 32'd0);
                check("access_cycles", acc_cnt, acc_exp);
            end else begin
                check("m0_prdata_zero", m0_if.prdata, 32'd0);
                check("m1_prdata_zero", m1_if.prdata, 32'd0);
                check("pslverr_zero", 32'({m0_if.pslverr, m1_if.pslverr}), 32'd0);
                check("timeout_err_stray", 32'(timeout_err), 32'd0);
            end
            if (s_if.psel && !s_if.penable) begin
                if (req_snap == 2'b00) fail("grant_without_request");
                else begin
                    owner = (req_snap == 2'b11) ? 1 - last_served : int'(req_snap[1]);
                    check("setup_grant", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
                    check("setup_paddr", 32'(s_if.paddr), 32'(cur_addr[owner]));
                    check("setup_pwrite", 32'(s_if.pwrite), 32'(cur_wr[owner]));
                    if (cur_wr[owner]) check("setup_pwdata", s_if.pwdata, cur_wdata[owner]);
                    last_served = owner;
                    acc_exp = hangs(cur_addr[owner]) ? TMO : int'(cur_addr[owner][1:0]) + 1;
                    acc_cnt = 0;
                end
            end
            if (s_if.psel && s_if.penable) begin
                acc_cnt++;
                check("access_grant", 32'(grant), (owner == 1) ? 32'd2 : 32'd1);
                check("access_paddr", 32'(s_if.paddr), 32'(cur_addr[owner]));
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        last_served = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        check("rst_s_psel", 32'(s_if.psel), 32'd0);
        check("rst_s_penable", 32'(s_if.penable), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_pready", 32'({m0_if.pready, m1_if.pready}), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_prdata", m0_if.prdata | m1_if.prdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single write from m0, zero-wait slave
        do_xfer(0, 1'b1, 16'h6564, 32'h0D0C0B0A, 3);
        // single read from m1, three wait states
        do_xfer(1, 1'b0, 16'h0C0B, 32'h0, 6);

        // simultaneous requests from reset: m0 first, then alternate
        apply_reset();
        repeat (2) begin
            fork
                do_xfer(0, 1'b0, 16'h1230, 32'h0, -1);
                do_xfer(1, 1'b1, 16'h4561, 32'hCAFE_0001, -1);
            join
        end

        // hung slave: timeout after 16 access cycles, then a normal transfer
        do_xfer(0, 1'b0, 16'hF000, 32'h0, 2 + TMO);
        do_xfer(0, 1'b0, 16'h0102, 32'h0, 5);

        // slave error on m1 write
        do_xfer(1, 1'b1, 16'h0E10, 32'h1111_2222, 3);

        // asynchronous reset during ACCESS
        cur_addr[0] = 16'h0C03; cur_wr[0] = 1'b0; cur_wdata[0] = 32'h0;
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0C03, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0C03, 32'h0);
        k = 0;
        while (!s_if.penable && k < 10) begin @(posedge clk); #1; k++; end
        check("reached_access", 32'(s_if.penable), 32'd1);
        #2;
        rst_n = 1'b0;
        last_served = 1;
        #1;
        check("async_rst_psel", 32'(s_if.psel), 32'd0);
        check("async_rst_penable", 32'(s_if.penable), 32'd0);
        check("async_rst_grant", 32'(grant), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check("no_pready_in_reset", 32'({m0_if.pready, m1_if.pready}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_xfer(1, 1'b0, 16'h2341, 32'h0, 4);

        // randomized concurrent traffic from both masters
        fork
            rand_master(0, 25);
            rand_master(1, 25);
        join
        repeat (5) begin @(posedge clk); #1; end
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
